// File: rtl/ram_burst_arbiter.sv
// Round-robin read-port arbiter for the one-cycle-latency weight/activation RAM.
// Two clients request bursts of consecutive words and receive their tagged read data.
module ram_burst_arbiter #(
    parameter int D_WIDTH = 16,
    parameter int A_WIDTH = 10,
    parameter int L_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic [A_WIDTH-1:0] base0,
    input  logic [L_WIDTH-1:0] len0,
    output logic               ack0,
    output logic               rvalid0,
    output logic               rlast0,
    output logic [D_WIDTH-1:0] rdata0,
    input  logic               req1,
    input  logic [A_WIDTH-1:0] base1,
    input  logic [L_WIDTH-1:0] len1,
    output logic               ack1,
    output logic               rvalid1,
    output logic               rlast1,
    output logic [D_WIDTH-1:0] rdata1,
    output logic [A_WIDTH-1:0] ram_r_addr,
    input  logic [D_WIDTH-1:0] ram_data_out,
    output logic               busy
);

    // Handshake: reqN is a level held (with baseN/lenN stable) until the one-cycle
    // ackN pulse; it is only sampled in IDLE and must be low in the ack cycle.
    typedef enum logic {IDLE, BURST} state_t;

    state_t             state, state_nxt;
    logic               grant, winner;
    logic               owner, last_owner;
    logic               ack0_q, ack1_q;
    logic [A_WIDTH-1:0] cur_addr;
    logic [L_WIDTH-1:0] remaining;
    logic               issue_valid, issue_owner, issue_last;
    logic [D_WIDTH-1:0] rdata0_q, rdata1_q;

    always_comb begin
        grant     = 1'b0;
        winner    = last_owner;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant     = 1'b1;
                    winner    = (req0 && req1) ? ~last_owner : req1;
                    state_nxt = BURST;
                end
            end
            BURST: begin
                if (remaining == '0)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_owner  <= 1'b1;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            cur_addr    <= '0;
            remaining   <= '0;
            issue_valid <= 1'b0;
            issue_owner <= 1'b0;
            issue_last  <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state  <= state_nxt;
            ack0_q <= grant & ~winner;
            ack1_q <= grant & winner;
            if (grant) begin
                owner      <= winner;
                last_owner <= winner;
                cur_addr   <= winner ? base1 : base0;
                remaining  <= winner ? len1 : len0;
            end else if (state == BURST) begin
                // address wraps naturally at 2**A_WIDTH
                cur_addr  <= cur_addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            // return pipeline tracks the RAM's one-cycle read latency
            issue_valid <= (state == BURST);
            issue_owner <= owner;
            issue_last  <= (state == BURST) && (remaining == '0);
            if (rvalid0)
                rdata0_q <= ram_data_out;
            if (rvalid1)
                rdata1_q <= ram_data_out;
        end
    end

    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign busy       = (state == BURST);
    assign ram_r_addr = cur_addr;
    assign rvalid0    = issue_valid & ~issue_owner;
    assign rvalid1    = issue_valid & issue_owner;
    assign rlast0     = rvalid0 & issue_last;
    assign rlast1     = rvalid1 & issue_last;
    assign rdata0     = rvalid0 ? ram_data_out : rdata0_q;
    assign rdata1     = rvalid1 ? ram_data_out : rdata1_q;

endmodule

// File: tb/tb_ram_burst_arbiter.sv
// Bench for ram_burst_arbiter: directed table, hand-written corner sequences and
// random traffic checked against a cycle-indexed burst model plus a data queue.
module tb_ram_burst_arbiter;
  localparam int MAXC = 4096;

  logic clk, rst;
  logic req0, req1, ack0, ack1, rvalid0, rvalid1, rlast0, rlast1, busy;
  logic [9:0] base0, base1, ram_r_addr;
  logic [7:0] len0, len1;
  logic [15:0] rdata0, rdata1, ram_data_out;
  logic [15:0] mem [1024];

  ram_burst_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .base0(base0), .len0(len0), .ack0(ack0),
    .rvalid0(rvalid0), .rlast0(rlast0), .rdata0(rdata0),
    .req1(req1), .base1(base1), .len1(len1), .ack1(ack1),
    .rvalid1(rvalid1), .rlast1(rlast1), .rdata1(rdata1),
    .ram_r_addr(ram_r_addr), .ram_data_out(ram_data_out), .busy(busy)
  );

  // clock/reset block and RAM behaviour (one-cycle read latency)
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) ram_data_out <= mem[ram_r_addr];

  // reference model state
  int total = 0, bad = 0, cyc = 0, m_idle_from = 0;
  bit m_lo;
  bit exp_ack [2][MAXC];
  bit exp_rv [2][MAXC];
  bit exp_busy [MAXC];
  logic [9:0] exp_addr [MAXC];
  logic [17:0] exp_q[$];
  logic [15:0] hold [2];
  int cnt_rv0, cnt_rl0, cnt_busy;

  typedef struct {
    bit r0; logic [9:0] b0; logic [7:0] l0;
    bit r1; logic [9:0] b1; logic [7:0] l1;
    bit e_ack0; bit e_ack1; logic [9:0] e_addr;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  // Model: a request seen in an idle cycle n grants the burst; ack at n+1,
  // addresses n+1..n+1+len, data n+2..n+2+len, next idle cycle n+2+len.
  task automatic model_tick();
    int w, b, l, a;
    if (cyc >= m_idle_from && (req0 || req1)) begin
      w = (req0 && req1) ? (m_lo ? 0 : 1) : (req1 ? 1 : 0);
      b = w ? int'(base1) : int'(base0);
      l = w ? int'(len1) : int'(len0);
      m_lo = (w == 1);
      exp_ack[w][cyc+1] = 1'b1;
      for (int i = 0; i <= l; i++) begin
        a = (b + i) % 1024;
        exp_busy[cyc+1+i] = 1'b1;
        exp_addr[cyc+1+i] = 10'(a);
        exp_rv[w][cyc+2+i] = 1'b1;
        exp_q.push_back({(w == 1), (i == l), mem[a]});
      end
      m_idle_from = cyc + l + 2;
    end
  endtask

  task automatic check_outputs();
    logic rv, rl;
    logic [15:0] rd;
    logic [17:0] e;
    chk("ack0", ack0, exp_ack[0][cyc]);
    chk("ack1", ack1, exp_ack[1][cyc]);
    chk("busy", busy, exp_busy[cyc]);
    if (exp_busy[cyc]) chk("ram_r_addr", ram_r_addr, exp_addr[cyc]);
    chk("rvalid0", rvalid0, exp_rv[0][cyc]);
    chk("rvalid1", rvalid1, exp_rv[1][cyc]);
    for (int c = 0; c < 2; c++) begin
      rv = c ? rvalid1 : rvalid0;
      rl = c ? rlast1 : rlast0;
      rd = c ? rdata1 : rdata0;
      if (rv === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_word cyc=%0d client=%0d got=%0h want=none", cyc, c, rd);
        end else begin
          e = exp_q.pop_front();
          chk("word_owner", c, e[17]);
          chk("rlast", rl, e[16]);
          chk("rdata", rd, e[15:0]);
          hold[c] = e[15:0];
        end
      end else begin
        chk("rlast_idle", rl, 1'b0);
        chk("rdata_hold", rd, hold[c]);
      end
    end
    if (rvalid0 === 1'b1) cnt_rv0++;
    if (rlast0 === 1'b1) cnt_rl0++;
    if (busy === 1'b1) cnt_busy++;
  endtask

  // driver: advance one cycle; requesters drop req in their ack cycle
  task automatic tick();
    model_tick();
    @(negedge clk);
    cyc++;
    check_outputs();
    if (req0 && exp_ack[0][cyc]) req0 = 1'b0;
    if (req1 && exp_ack[1][cyc]) req1 = 1'b0;
  endtask

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_ack0", ack0, 0); chk("rst_ack1", ack1, 0);
    chk("rst_rvalid0", rvalid0, 0); chk("rst_rvalid1", rvalid1, 0);
    chk("rst_rlast0", rlast0, 0); chk("rst_rlast1", rlast1, 0);
    chk("rst_rdata0", rdata0, 0); chk("rst_rdata1", rdata1, 0);
    chk("rst_busy", busy, 0); chk("rst_addr", ram_r_addr, 0);
    for (int n = cyc + 1; n < MAXC; n++) begin
      exp_ack[0][n] = 0; exp_ack[1][n] = 0; exp_rv[0][n] = 0; exp_rv[1][n] = 0;
      exp_busy[n] = 0;
    end
    exp_q.delete();
    hold[0] = '0; hold[1] = '0;
    m_lo = 1'b1;
    @(negedge clk);
    cyc++;
    check_outputs();
    rst = 1'b0;
    m_idle_from = cyc;
  endtask

  initial begin
    int t, got, lw;
    rst = 1'b0; req0 = 0; req1 = 0; base0 = '0; base1 = '0; len0 = '0; len1 = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    vecs[0] = '{1, 10'h010, 8'd3, 0, 10'h000, 8'd0, 1, 0, 10'h010};
    vecs[1] = '{1, 10'h000, 8'd0, 1, 10'h100, 8'd1, 0, 1, 10'h100};
    vecs[2] = '{1, 10'h000, 8'd0, 1, 10'h100, 8'd1, 1, 0, 10'h000};
    vecs[3] = '{0, 10'h000, 8'd0, 1, 10'h3FE, 8'd3, 0, 1, 10'h3FE};
    vecs[4] = '{0, 10'h000, 8'd0, 1, 10'h020, 8'd0, 0, 1, 10'h020};
    vecs[5] = '{1, 10'h030, 8'd2, 1, 10'h040, 8'd2, 1, 0, 10'h030};
    vecs[6] = '{1, 10'h3FF, 8'd1, 0, 10'h000, 8'd0, 1, 0, 10'h3FF};
    vecs[7] = '{1, 10'h200, 8'd0, 1, 10'h300, 8'd0, 0, 1, 10'h300};

    @(negedge clk);
    do_reset();
    tick();

    // directed table: one burst per record from an idle arbiter
    for (int v = 0; v < 8; v++) begin
      req0 = vecs[v].r0; base0 = vecs[v].b0; len0 = vecs[v].l0;
      req1 = vecs[v].r1; base1 = vecs[v].b1; len1 = vecs[v].l1;
      tick();
      chk("tbl_ack0", ack0, vecs[v].e_ack0);
      chk("tbl_ack1", ack1, vecs[v].e_ack1);
      chk("tbl_first_addr", ram_r_addr, vecs[v].e_addr);
      req0 = 0; req1 = 0;
      lw = vecs[v].e_ack1 ? int'(vecs[v].l1) : int'(vecs[v].l0);
      repeat (lw + 3) tick();
    end

    // tie from reset: client 0, then client 1 after one idle cycle, then client 0
    do_reset();
    req0 = 1; base0 = 10'h000; len0 = 8'd0;
    req1 = 1; base1 = 10'h100; len1 = 8'd1;
    tick(); chk("tie_first_ack0", ack0, 1); chk("tie_first_ack1", ack1, 0);
    tick(); chk("tie_idle_gap_ack1", ack1, 0);
    tick(); chk("tie_second_ack1", ack1, 1); chk("tie_second_addr", ram_r_addr, 10'h100);
    tick(); tick();
    req0 = 1; req1 = 1;
    tick(); chk("tie_third_ack0", ack0, 1); chk("tie_third_ack1", ack1, 0);
    req1 = 0;
    repeat (4) tick();

    // req1 raised mid client-0 burst
    t = cyc;
    req0 = 1; base0 = 10'h080; len0 = 8'd4;
    tick(); tick();
    req1 = 1; base1 = 10'h090; len1 = 8'd1;
    got = -1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ack1 === 1'b1) begin got = cyc; break; end
    end
    chk("mid_burst_ack1_cycle", got, t + 7);
    repeat (5) tick();

    // maximum burst length
    cnt_rv0 = 0; cnt_rl0 = 0; cnt_busy = 0;
    req0 = 1; base0 = 10'h123; len0 = 8'hFF;
    repeat (262) tick();
    chk("max_rvalid0_count", cnt_rv0, 256);
    chk("max_rlast0_count", cnt_rl0, 1);
    chk("max_busy_count", cnt_busy, 256);

    // reset after two of five words
    req0 = 1; base0 = 10'h050; len0 = 8'd4;
    tick(); tick(); tick();
    do_reset();
    repeat (6) tick();
    req0 = 1; base0 = 10'h060; len0 = 8'd1;
    req1 = 1; base1 = 10'h070; len1 = 8'd1;
    tick(); chk("post_rst_tie_ack0", ack0, 1); chk("post_rst_tie_ack1", ack1, 0);
    chk("post_rst_addr", ram_r_addr, 10'h060);
    repeat (8) tick();

    // random traffic
    for (int k = 0; k < 2500 && cyc < MAXC - 600; k++) begin
      if (!req0 && !exp_ack[0][cyc] && $urandom_range(0, 3) == 0) begin
        req0 = 1; base0 = 10'($urandom_range(0, 1023));
        len0 = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
      end
      if (!req1 && !exp_ack[1][cyc] && $urandom_range(0, 3) == 0) begin
        req1 = 1; base1 = 10'($urandom_range(0, 1023));
        len1 = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
      end
      tick();
    end
    repeat (300) tick();
    chk("words_outstanding", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_burst_arbiter.md
Name: ram_burst_arbiter

Overview:
- Read-side controller for the single-port-read, one-cycle-latency weight/activation RAM.
- Shares the RAM read port between two requesters, e.g. the weight fetch and activation fetch engines of the DNN datapath.
- Each requester asks for a burst of consecutive words. The block arbitrates round-robin, sequences the addresses and returns tagged data.
- The RAM write port is not driven by this block.

Parameters:
- D_WIDTH, 16, RAM data width
- A_WIDTH, 10, RAM address width (depth 2**A_WIDTH)
- L_WIDTH, 8, burst length field width (burst = len+1 words, 1..2**L_WIDTH)

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- req0  input  1  client 0 burst request, held until ack0
- base0  input  A_WIDTH  client 0 start address, stable while req0 high
- len0  input  L_WIDTH  client 0 burst length minus one
- ack0  output  1  one-cycle pulse: client 0 burst accepted
- rvalid0  output  1  client 0 read data valid
- rlast0  output  1  marks last word of client 0 burst
- rdata0  output  D_WIDTH  client 0 read data
- req1, base1, len1, ack1, rvalid1, rlast1, rdata1: same as client 0, for client 1
- ram_r_addr  output  A_WIDTH  to RAM r_addr
- ram_data_out  input  D_WIDTH  from RAM data_out (valid one cycle after address)
- busy  output  1  high while a burst is being issued

Behaviour:
- Reset (async, immediate):
  - state=IDLE; ack*, rvalid*, rlast*, busy=0.
  - rdata*=0; ram_r_addr=0.
  - last_owner=1, so client 0 wins the first tie.
- Clock: one clock (clk); reset asynchronous, active-high (rst).
- FSM IDLE:
  - Arbitration:
    - Only one req high: that client wins.
    - Both high: client != last_owner wins.
    - None high: stay IDLE.
  - On the edge ending a winning cycle:
    - owner<=winner, last_owner<=winner.
    - cur_addr<=base_w, remaining<=len_w.
    - ack_w<=1 for exactly one cycle; state<=BURST.
- FSM BURST:
  - busy=1; ram_r_addr=cur_addr (registered).
  - Each cycle issues one address: cur_addr<=cur_addr+1, modulo 2**A_WIDTH (wrap 2**A_WIDTH-1 -> 0).
  - remaining decrements each cycle.
  - The cycle issuing the address with remaining==0 is the last issue; next state IDLE.
  - Exactly len+1 addresses are issued.
- Request rules:
  - Requests are not sampled during BURST; arbitration occurs only in IDLE.
  - One idle cycle separates consecutive bursts.
  - Requester must drop req in the cycle ack is seen. If req is still high in a later IDLE cycle, it counts as a new request.
- Return path:
  - Registered pipeline: issue_valid, issue_owner, issue_last follow each issued address by one cycle.
  - rvalid_owner=1 and rdata_owner=ram_data_out in the cycle after address issue, i.e. the RAM read latency. rlast_owner marks the word from the last issued address.
  - The other client's rvalid stays 0. rdata of a non-valid client holds its last value.
  - The last word's rvalid can coincide with an IDLE cycle and a new arbitration; this is legal.
- Latency: req seen in IDLE cycle t; ack during t+1; first address during t+1; first rvalid at t+2; last rvalid at t+2+len.
- Writes: the write port may be driven concurrently by the loader. The RAM behaves write-first to a same-cycle read address; no interlock is performed.
- Reset mid-burst: burst abandoned, no further rvalid/rlast. Pending ack is cleared. Fairness pointer returns to favour client 0.

Test Plan:
- Reset, then req0=1, base0=0x010, len0=3 -> ack0 at t+1; ram_r_addr 0x010..0x013 at t+1..t+4; rvalid0 at t+2..t+5 with RAM contents; rlast0 only at t+5; rvalid1 never high.
- req0 and req1 both high from reset (base0=0x000 len0=0, base1=0x100 len1=1) -> client 0 granted first (1 word). After one idle cycle, client 1 granted (2 words, 0x100, 0x101). A third tie then goes to client 0.
- Wrap-around: base1=0x3FE, len1=3, A_WIDTH=10 -> addresses 0x3FE, 0x3FF, 0x000, 0x001; rlast1 on the 0x001 word.
- Maximum burst: len0=0xFF -> exactly 256 rvalid0 pulses, busy high 256 cycles, one rlast0.
- req1 asserted mid client-0 burst -> no ack1 until client-0 burst ends; ack1 exactly one cycle after the first IDLE cycle.
- rst pulsed mid-burst (after 2 of 5 words) -> outputs 0 immediately; no further rvalid. A subsequent tie is granted to client 0.
